// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: receiver FSM encoding and scan-code prefix bytes
// used by both the receiver and the downstream scan-code decoder.
package ps2_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DATA   = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;
  localparam logic [1:0] ST_STOP   = 2'd3;

  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam logic [7:0] PS2_EXT   = 8'hE0;

  // PS/2 uses odd parity: data bits plus parity bit must hold an odd number of ones.
  function automatic logic oddParityOk(input logic [7:0] dataBits, input logic parityBit);
    return ^{dataBits, parityBit};
  endfunction

endpackage

// File: rtl/ps2_sync_filter.sv
// Synchronizes the PS/2 pad signals, deglitches ps2_clk over FILTER_LEN
// samples and emits a one-cycle strobe on each filtered falling edge.
module ps2_sync_filter
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic ps2_clk_i,
  input  logic ps2_data_i,
  output logic data_sync_o,
  output logic fall_stb_o
);

  localparam int CW = (FILTER_LEN < 2) ? 1 : $clog2(FILTER_LEN + 1);

  logic          clkMeta_q, clkSync_q;
  logic          dataMeta_q, dataSync_q;
  logic          filtClk_q, filtClk_d;
  logic          fallStb_q, fallStb_d;
  logic [CW-1:0] filtCnt_q, filtCnt_d;

  // The filtered clock only follows the synchronized clock once it has
  // disagreed for FILTER_LEN consecutive samples; any agreement restarts the run.
  always_comb begin
    filtClk_d = filtClk_q;
    filtCnt_d = '0;
    fallStb_d = 1'b0;
    if (clkSync_q != filtClk_q) begin
      if (filtCnt_q == CW'(FILTER_LEN - 1)) begin
        filtClk_d = clkSync_q;
        fallStb_d = filtClk_q;
      end else begin
        filtCnt_d = filtCnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      clkMeta_q  <= 1'b1;
      clkSync_q  <= 1'b1;
      dataMeta_q <= 1'b1;
      dataSync_q <= 1'b1;
      filtClk_q  <= 1'b1;
      filtCnt_q  <= '0;
      fallStb_q  <= 1'b0;
    end else begin
      clkMeta_q  <= ps2_clk_i;
      clkSync_q  <= clkMeta_q;
      dataMeta_q <= ps2_data_i;
      dataSync_q <= dataMeta_q;
      filtClk_q  <= filtClk_d;
      filtCnt_q  <= filtCnt_d;
      fallStb_q  <= fallStb_d;
    end
  end

  assign data_sync_o = dataSync_q;
  assign fall_stb_o  = fallStb_q;

endmodule

// File: rtl/ps2_receiver.sv
// PS/2 device-to-host frame receiver (start, 8 data LSB first, odd parity, stop).
// Define PS2_TIMEOUT_EN to abort frames that stall for TIMEOUT_CYCLES clocks.
module ps2_receiver
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] data,
  output logic       read_complete,
  output logic       parity_err,
  output logic       frame_err
);

  logic       dataSync;
  logic       fallStb;
  logic [1:0] state_q, state_d;
  logic [2:0] bitCnt_q, bitCnt_d;
  logic [7:0] shift_q, shift_d;
  logic       parity_q, parity_d;
  logic [7:0] data_q, data_d;
  logic       readComplete_q, readComplete_d;
  logic       parityErr_q, parityErr_d;
  logic       frameErr_q, frameErr_d;

  ps2_sync_filter #(
    .FILTER_LEN (FILTER_LEN)
  ) u_sync_filter (
    .clk_i       (clk),
    .rst_i       (rst),
    .ps2_clk_i   (ps2_clk),
    .ps2_data_i  (ps2_data),
    .data_sync_o (dataSync),
    .fall_stb_o  (fallStb)
  );

`ifdef PS2_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] toCnt_q, toCnt_d;
`endif

  always_comb begin
    state_d        = state_q;
    bitCnt_d       = bitCnt_q;
    shift_d        = shift_q;
    parity_d       = parity_q;
    data_d         = data_q;
    readComplete_d = 1'b0;
    parityErr_d    = 1'b0;
    frameErr_d     = 1'b0;
    if (fallStb) begin
      case (state_q)
        ST_IDLE: begin
          if (!dataSync) begin
            state_d  = ST_DATA;
            bitCnt_d = 3'd0;
          end
        end
        ST_DATA: begin
          shift_d  = {dataSync, shift_q[7:1]};
          bitCnt_d = bitCnt_q + 3'd1;
          if (bitCnt_q == 3'd7) state_d = ST_PARITY;
        end
        ST_PARITY: begin
          parity_d = dataSync;
          state_d  = ST_STOP;
        end
        default: begin
          state_d = ST_IDLE;
          // A bad stop bit outranks a parity error.
          if (!dataSync) begin
            frameErr_d = 1'b1;
          end else if (oddParityOk(shift_q, parity_q)) begin
            data_d         = shift_q;
            readComplete_d = 1'b1;
          end else begin
            parityErr_d = 1'b1;
          end
        end
      endcase
    end
`ifdef PS2_TIMEOUT_EN
    // Firing at TIMEOUT_CYCLES-2 puts the registered frame_err exactly
    // TIMEOUT_CYCLES cycles after the last strobe.
    toCnt_d = toCnt_q;
    if (state_q == ST_IDLE || fallStb) begin
      toCnt_d = '0;
    end else if (toCnt_q == TW'(TIMEOUT_CYCLES - 2)) begin
      toCnt_d    = '0;
      state_d    = ST_IDLE;
      frameErr_d = 1'b1;
    end else begin
      toCnt_d = toCnt_q + TW'(1);
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      bitCnt_q       <= 3'd0;
      shift_q        <= 8'h00;
      parity_q       <= 1'b0;
      data_q         <= 8'h00;
      readComplete_q <= 1'b0;
      parityErr_q    <= 1'b0;
      frameErr_q     <= 1'b0;
`ifdef PS2_TIMEOUT_EN
      toCnt_q        <= '0;
`endif
    end else begin
      state_q        <= state_d;
      bitCnt_q       <= bitCnt_d;
      shift_q        <= shift_d;
      parity_q       <= parity_d;
      data_q         <= data_d;
      readComplete_q <= readComplete_d;
      parityErr_q    <= parityErr_d;
      frameErr_q     <= frameErr_d;
`ifdef PS2_TIMEOUT_EN
      toCnt_q        <= toCnt_d;
`endif
    end
  end

  assign data          = data_q;
  assign read_complete = readComplete_q;
  assign parity_err    = parityErr_q;
  assign frame_err     = frameErr_q;

endmodule

// File: tb/tb_ps2_receiver.sv
// Self-checking bench for ps2_receiver: directed and random PS/2 frames
// compared against a frame-level model; honours PS2_TIMEOUT_EN.
module tb_ps2_receiver;

  localparam int FILTER_LEN = 8;
  localparam int TIMEOUT    = 3000;

  logic       clock = 1'b0;
  logic       reset;
  logic       ps2Clk;
  logic       ps2Data;
  logic [7:0] data;
  logic       readComplete;
  logic       parityErr;
  logic       frameErr;

  int checks = 0;
  int failures = 0;
  int rcCount = 0, peCount = 0, feCount = 0;
  int overlapCount = 0, illegalDataChange = 0;
  int cycleNo = 0, feCycle = 0, lastFallCycle = 0;
  logic [7:0] prevData = 8'h00;
  logic [7:0] modelData;

  ps2_receiver #(
    .FILTER_LEN     (FILTER_LEN),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clk           (clock),
    .rst           (reset),
    .ps2_clk       (ps2Clk),
    .ps2_data      (ps2Data),
    .data          (data),
    .read_complete (readComplete),
    .parity_err    (parityErr),
    .frame_err     (frameErr)
  );

  always #5 clock = ~clock;

  // Pulse bookkeeping sampled mid-cycle, away from the active edge.
  always @(negedge clock) begin
    cycleNo  <= cycleNo + 1;
    prevData <= data;
    if (!reset) begin
      if (readComplete) rcCount <= rcCount + 1;
      if (parityErr) peCount <= peCount + 1;
      if (frameErr) begin
        feCount <= feCount + 1;
        feCycle <= cycleNo;
      end
      if ((int'(readComplete) + int'(parityErr) + int'(frameErr)) > 1)
        overlapCount <= overlapCount + 1;
      if (data != prevData && !readComplete)
        illegalDataChange <= illegalDataChange + 1;
    end
  end

  task automatic checkOutput(input string tag, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Drives the first nBits bits of a frame; each bit is set up while the clock is high.
  task automatic sendFrame(input logic [7:0] b, input bit badParity, input bit badStop,
                           input int nBits);
    logic [10:0] frame;
    int halfP;
    halfP = $urandom_range(30, 50);
    frame = {~badStop, (~^b) ^ badParity, b, 1'b0};
    for (int i = 0; i < nBits; i++) begin
      ps2Data = frame[i];
      repeat (halfP) @(negedge clock);
      ps2Clk = 1'b0;
      lastFallCycle = cycleNo;
      repeat (halfP) @(negedge clock);
      ps2Clk = 1'b1;
    end
  endtask

  // Full frame followed by a comparison against the frame-level rules.
  task automatic applyStimulus(input string tag, input logic [7:0] b, input bit badParity,
                               input bit badStop);
    int rc0, pe0, fe0, expRc, expPe, expFe;
    rc0 = rcCount; pe0 = peCount; fe0 = feCount;
    expRc = 0; expPe = 0; expFe = 0;
    if (badStop) expFe = 1;
    else if (badParity) expPe = 1;
    else begin
      expRc = 1;
      modelData = b;
    end
    sendFrame(b, badParity, badStop, 11);
    #1;
    checkOutput({tag, "_rc"}, rcCount - rc0, expRc);
    checkOutput({tag, "_pe"}, peCount - pe0, expPe);
    checkOutput({tag, "_fe"}, feCount - fe0, expFe);
    checkOutput({tag, "_data"}, int'(data), int'(modelData));
  endtask

  task automatic pulseReset(input int cycles);
    @(negedge clock);
    reset = 1'b1;
    repeat (cycles) @(negedge clock);
    reset = 1'b0;
    modelData = 8'h00;
  endtask

  initial begin
    int rc0, pe0, fe0, lat, kind;
    logic [7:0] rb;
    reset = 1'b1;
    ps2Clk = 1'b1;
    ps2Data = 1'b1;
    modelData = 8'h00;
    repeat (5) @(negedge clock);
    checkOutput("reset_data", int'(data), 0);
    checkOutput("reset_rc", int'(readComplete), 0);
    checkOutput("reset_pe", int'(parityErr), 0);
    checkOutput("reset_fe", int'(frameErr), 0);
    reset = 1'b0;
    repeat (20) @(negedge clock);
    checkOutput("idle_data", int'(data), 0);

    applyStimulus("f1C", 8'h1C, 1'b0, 1'b0);
    applyStimulus("bbF0", 8'hF0, 1'b0, 1'b0);
    applyStimulus("bb1C", 8'h1C, 1'b0, 1'b0);
    applyStimulus("par29", 8'h29, 1'b1, 1'b0);
    applyStimulus("stop29", 8'h29, 1'b0, 1'b1);
    applyStimulus("f5A", 8'h5A, 1'b0, 1'b0);
    applyStimulus("fE0", 8'hE0, 1'b0, 1'b0);
    applyStimulus("stopPar", 8'h3C, 1'b1, 1'b1);

    // A 3-cycle clock glitch with data low must not be taken as a start bit.
    rc0 = rcCount; pe0 = peCount; fe0 = feCount;
    ps2Data = 1'b0;
    repeat (10) @(negedge clock);
    ps2Clk = 1'b0;
    repeat (3) @(negedge clock);
    ps2Clk = 1'b1;
    repeat (30) @(negedge clock);
    ps2Data = 1'b1;
    #1;
    checkOutput("glitch_pulses", (rcCount - rc0) + (peCount - pe0) + (feCount - fe0), 0);
    applyStimulus("postGlitch", 8'hA5, 1'b0, 1'b0);

    for (int i = 0; i < 16; i++) begin
      rb = 8'($urandom_range(0, 255));
      kind = $urandom_range(0, 9);
      applyStimulus($sformatf("rnd%0d", i), rb, kind == 8, kind == 9);
    end

    // Reset after start plus four data bits discards the partial frame silently.
    rc0 = rcCount; pe0 = peCount; fe0 = feCount;
    sendFrame(8'h33, 1'b0, 1'b0, 5);
    pulseReset(4);
    repeat (40) @(negedge clock);
    #1;
    checkOutput("midReset_pulses", (rcCount - rc0) + (peCount - pe0) + (feCount - fe0), 0);
    checkOutput("midReset_data", int'(data), 0);
    applyStimulus("f75", 8'h75, 1'b0, 1'b0);

    // Truncated frame: start plus five data bits, then the clock stays high.
    fe0 = feCount; rc0 = rcCount;
    sendFrame(8'h6B, 1'b0, 1'b0, 6);
`ifdef PS2_TIMEOUT_EN
    for (int i = 0; i < TIMEOUT + 200 && feCount == fe0; i++) @(negedge clock);
    #1;
    lat = feCycle - lastFallCycle;
    checkOutput("timeout_fe", feCount - fe0, 1);
    checkOutput("timeout_latency", int'(lat >= TIMEOUT + FILTER_LEN && lat <= TIMEOUT + FILTER_LEN + 3), 1);
    checkOutput("timeout_rc", rcCount - rc0, 0);
    checkOutput("timeout_data", int'(data), int'(modelData));
    applyStimulus("postTimeout", 8'h4E, 1'b0, 1'b0);
`else
    lat = 0;
    repeat (TIMEOUT + 200) @(negedge clock);
    #1;
    checkOutput("stall_fe", feCount - fe0, lat);
    checkOutput("stall_rc", rcCount - rc0, 0);
    checkOutput("stall_data", int'(data), int'(modelData));
    pulseReset(4);
    repeat (20) @(negedge clock);
    applyStimulus("postStall", 8'h4E, 1'b0, 1'b0);
`endif

    repeat (20) @(negedge clock);
    #1;
    checkOutput("pulse_overlap", overlapCount, 0);
    checkOutput("data_change_without_rc", illegalDataChange, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ps2_receiver.md
PS2_RECEIVER -- requirements
Module: ps2_receiver

Interface
REQ-001 SHALL have parameter FILTER_LEN, default 8: consecutive equal synchronized ps2_clk samples required before the filtered clock changes.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 50000: idle clk cycles mid-frame before abort (1 ms at 50 MHz).
REQ-003 SHALL have port clk  input  1  system clock; single clock domain.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port ps2_clk  input  1  raw PS/2 clock from the pad, asynchronous.
REQ-006 SHALL have port ps2_data  input  1  raw PS/2 data from the pad, asynchronous.
REQ-007 SHALL have port data  output  8  last correctly received byte; held until the next good frame.
REQ-008 SHALL have port read_complete  output  1  one-cycle pulse when data is updated.
REQ-009 SHALL have port parity_err  output  1  one-cycle pulse on a frame with bad odd parity.
REQ-010 SHALL have port frame_err  output  1  one-cycle pulse on a bad stop bit or a timeout.

Function
REQ-011 SHALL pass ps2_clk and ps2_data through 2-flop synchronizers, each reset to 1 (bus idle high).
REQ-012 SHALL change filtered clock only after FILTER_LEN consecutive identical synchronized samples.
REQ-013 SHALL detect a falling edge of the filtered clock as a one-cycle strobe.
REQ-014 SHALL sample synchronized ps2_data only in cycles with the falling-edge strobe.
REQ-015 SHALL implement FSM states IDLE, DATA, PARITY, STOP.
REQ-016 In IDLE, a strobe with data 0 SHALL go to DATA with bit count 0; with data 1, the FSM SHALL stay in IDLE (spurious start ignored).
REQ-017 In DATA, the FSM SHALL shift in 8 bits LSB first, then go to PARITY after the 8th strobe.
REQ-018 In PARITY, the FSM SHALL store the parity bit, then go to STOP.
REQ-019 In STOP, on the strobe, the FSM SHALL return to IDLE and evaluate the frame:
  - stop=1 and odd parity over 8 data bits plus parity: update data and pulse read_complete;
  - stop=1 and parity bad: pulse parity_err; data unchanged; no read_complete;
  - stop=0: pulse frame_err; data unchanged; no read_complete (takes priority over parity_err).
REQ-020 SHALL register the pulses in REQ-019 to assert exactly one clk cycle after the stop-bit strobe cycle; at most one of the three pulses is high in any cycle.
REQ-021 SHALL accept a new start bit on the next strobe after returning to IDLE (back-to-back frames, no gap required).
REQ-022 SHALL deliver bytes 0xE0 and 0xF0 like any other byte; prefix interpretation belongs downstream.

Reset
REQ-023 On rst, the block SHALL set: FSM to IDLE, bit count 0, shift register 0, data 8'h00, read_complete/parity_err/frame_err 0, synchronizers and filtered clock 1, filter and timeout counters 0.
REQ-024 Reset asserted mid-frame SHALL discard the partial frame with no pulse; the first frame after reset release SHALL start from IDLE.

Configuration
REQ-025 Macro PS2_TIMEOUT_EN defined: in any non-IDLE state, the block SHALL count clk cycles, clearing the count on each strobe; when the count reaches TIMEOUT_CYCLES, it SHALL go to IDLE, pulse frame_err once, and leave data unchanged.
REQ-026 Macro PS2_TIMEOUT_EN undefined: the block SHALL have no timeout counter; frame_err pulses only for stop=0; a truncated frame stalls until further edges arrive.

Structure
REQ-027 Package ps2_pkg SHALL hold the FSM state encoding and the constants PS2_BREAK=8'hF0 and PS2_EXT=8'hE0, shared with the downstream scan-code decoder.
REQ-028 Sub-module ps2_sync_filter SHALL contain the synchronizer plus FILTER_LEN glitch filter plus falling-edge strobe for ps2_clk; ps2_data uses the synchronizer only.
REQ-029 ps2_receiver SHALL drive read_complete/data directly into the keyboard decoder's byte input with no extra buffering.

Verification
REQ-030 Frame 0x1C (start 0, bits LSB first, parity 0, stop 1) at 12.5 kHz -> data=8'h1C, a single read_complete pulse, no error pulses.
REQ-031 Frames 0xF0 then 0x1C back-to-back -> two read_complete pulses; data=8'hF0 then 8'h1C.
REQ-032 Frame 0x29 with parity inverted -> one parity_err pulse; data keeps its previous value; no read_complete.
REQ-033 Frame 0x29 with stop bit 0 -> one frame_err pulse; next good frame 0x5A is received correctly.
REQ-034 ps2_clk glitch low for 3 cycles (FILTER_LEN=8) while in IDLE -> no strobe, FSM stays in IDLE; rst asserted after 4 data bits -> no pulse, next frame 0x75 is received correctly.
REQ-035 With PS2_TIMEOUT_EN defined: frame stops after 5 bits -> frame_err exactly TIMEOUT_CYCLES after the last strobe, FSM returns to IDLE; without PS2_TIMEOUT_EN -> no pulse.
